// File: rtl/video_pattern_gen_pkg.sv
// video_pkg: pattern mode encodings, bar colour masks and standard raster timing sets
// shared by the video test-pattern source.
package video_pkg;

  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_SOLID   = 2'd3
  } pat_mode_e;

  typedef struct packed {
    logic [CNT_W-1:0] h_active;
    logic [CNT_W-1:0] h_fp;
    logic [CNT_W-1:0] h_sync;
    logic [CNT_W-1:0] h_bp;
    logic [CNT_W-1:0] v_active;
    logic [CNT_W-1:0] v_fp;
    logic [CNT_W-1:0] v_sync;
    logic [CNT_W-1:0] v_bp;
  } timing_t;

  localparam timing_t TIMING_480X272 = '{h_active: 12'd480, h_fp: 12'd2, h_sync: 12'd41, h_bp: 12'd2,
                                         v_active: 12'd272, v_fp: 12'd2, v_sync: 12'd10, v_bp: 12'd2};
  localparam timing_t TIMING_640X480 = '{h_active: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
                                         v_active: 12'd480, v_fp: 12'd10, v_sync: 12'd2, v_bp: 12'd33};
  localparam timing_t TIMING_800X600 = '{h_active: 12'd800, h_fp: 12'd40, h_sync: 12'd128, h_bp: 12'd88,
                                         v_active: 12'd600, v_fp: 12'd1, v_sync: 12'd4, v_bp: 12'd23};
  localparam timing_t TIMING_1280X720 = '{h_active: 12'd1280, h_fp: 12'd110, h_sync: 12'd40, h_bp: 12'd220,
                                          v_active: 12'd720, v_fp: 12'd5, v_sync: 12'd5, v_bp: 12'd20};
  localparam timing_t TIMING_1920X1080 = '{h_active: 12'd1920, h_fp: 12'd88, h_sync: 12'd44, h_bp: 12'd148,
                                           v_active: 12'd1080, v_fp: 12'd4, v_sync: 12'd5, v_bp: 12'd36};

  // Bar colours left to right as {r,g,b} on/off masks.
  function automatic logic [2:0] bar_mask(input logic [2:0] idx);
    logic [2:0] m;
    case (idx)
      3'd0:    m = 3'b111;
      3'd1:    m = 3'b110;
      3'd2:    m = 3'b011;
      3'd3:    m = 3'b010;
      3'd4:    m = 3'b101;
      3'd5:    m = 3'b100;
      3'd6:    m = 3'b001;
      3'd7:    m = 3'b000;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// Video source bus: pattern controls in, sync/enable/pixel data out.
interface video_pattern_gen_if #(
  parameter int COLOR_W = 8
);
  logic [1:0]           mode;
  logic [3*COLOR_W-1:0] solid_rgb;
  logic                 hs;
  logic                 vs;
  logic                 de;
  logic [COLOR_W-1:0]   rgb_r;
  logic [COLOR_W-1:0]   rgb_g;
  logic [COLOR_W-1:0]   rgb_b;
  logic                 frame_start;

  modport master (
    input  mode, solid_rgb,
    output hs, vs, de, rgb_r, rgb_g, rgb_b, frame_start
  );

  modport slave (
    output mode, solid_rgb,
    input  hs, vs, de, rgb_r, rgb_g, rgb_b, frame_start
  );
endinterface

// File: rtl/video_pattern_gen_timing.sv
// video_timing_gen: raster counters and the first pipeline stage (sync/enable decode,
// active-area coordinates and frame-start flag), all registered.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20
) (
  input  logic             clk,
  input  logic             rst,
  output logic             o_origin,
  output logic             o_hs_act,
  output logic             o_vs_act,
  output logic             o_de,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_frame_start
);

  localparam int H_BLANK = H_FP + H_SYNC + H_BP;
  localparam int V_BLANK = V_FP + V_SYNC + V_BP;
  localparam int H_TOTAL = H_BLANK + H_ACTIVE;
  localparam int V_TOTAL = V_BLANK + V_ACTIVE;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_ON  = CNT_W'(H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_OFF = CNT_W'(H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_ON  = CNT_W'(V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_OFF = CNT_W'(V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] H_BLANK_C  = CNT_W'(H_BLANK);
  localparam logic [CNT_W-1:0] V_BLANK_C  = CNT_W'(V_BLANK);

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_de;
  logic [CNT_W-1:0] w_x;
  logic [CNT_W-1:0] w_y;

  logic             r_hs_act;
  logic             r_vs_act;
  logic             r_de;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_frame_start;

  // Raster counters: h wraps every line, v steps on the last pixel of each line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= 12'd0;
      r_v_cnt <= 12'd0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= 12'd0;
      if (r_v_cnt == V_LAST) begin
        r_v_cnt <= 12'd0;
      end else begin
        r_v_cnt <= r_v_cnt + 12'd1;
      end
    end else begin
      r_h_cnt <= r_h_cnt + 12'd1;
    end
  end

  // Decode of the current counter state into syncs, enable and coordinates.
  always_comb begin
    w_hs_act = (r_h_cnt >= H_SYNC_ON) && (r_h_cnt < H_SYNC_OFF);
    w_vs_act = (r_v_cnt >= V_SYNC_ON) && (r_v_cnt < V_SYNC_OFF);
    w_de     = (r_h_cnt >= H_BLANK_C) && (r_v_cnt >= V_BLANK_C);
    if (w_de) begin
      w_x = r_h_cnt - H_BLANK_C;
      w_y = r_v_cnt - V_BLANK_C;
    end else begin
      w_x = 12'd0;
      w_y = 12'd0;
    end
  end

  assign o_origin = (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);

  // Stage-1 register; the sync flags are stored as "active" so reset reads inactive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs_act      <= 1'b0;
      r_vs_act      <= 1'b0;
      r_de          <= 1'b0;
      r_x           <= 12'd0;
      r_y           <= 12'd0;
      r_frame_start <= 1'b0;
    end else begin
      r_hs_act      <= w_hs_act;
      r_vs_act      <= w_vs_act;
      r_de          <= w_de;
      r_x           <= w_x;
      r_y           <= w_y;
      r_frame_start <= o_origin;
    end
  end

  assign o_hs_act      = r_hs_act;
  assign o_vs_act      = r_vs_act;
  assign o_de          = r_de;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: raster timing plus per-frame latched test pattern, 2-stage pipeline.
// Optional PATTERN_SCROLL_EN: bars/ramp/checker scroll left by one pixel per frame.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int COLOR_W  = 8,
  parameter int CHK_LOG2 = 5
) (
  input logic                 clk,
  input logic                 rst,
  video_pattern_gen_if.master bus
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic                 w_origin;
  logic                 w_hs_act;
  logic                 w_vs_act;
  logic                 w_de;
  logic [CNT_W-1:0]     w_x;
  logic [CNT_W-1:0]     w_y;
  logic                 w_fs;
  logic [CNT_W-1:0]     w_x_eff;
  logic [2:0]           w_bar_idx;
  logic [2:0]           w_mask;
  logic                 w_chk_x;
  logic                 w_chk_y;
  logic [3*COLOR_W-1:0] w_rgb;

  pat_mode_e            r_mode_q;
  logic [3*COLOR_W-1:0] r_solid_q;
  logic                 r_hs;
  logic                 r_vs;
  logic                 r_de;
  logic                 r_fs;
  logic [3*COLOR_W-1:0] r_rgb;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk           (clk),
    .rst           (rst),
    .o_origin      (w_origin),
    .o_hs_act      (w_hs_act),
    .o_vs_act      (w_vs_act),
    .o_de          (w_de),
    .o_x           (w_x),
    .o_y           (w_y),
    .o_frame_start (w_fs)
  );

  // Pattern controls are frozen at the frame origin so a frame never mixes patterns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_q  <= PAT_BARS;
      r_solid_q <= {(3*COLOR_W){1'b0}};
    end else if (w_origin) begin
      r_mode_q  <= pat_mode_e'(bus.mode);
      r_solid_q <= bus.solid_rgb;
    end
  end

`ifdef PATTERN_SCROLL_EN
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(H_ACTIVE - 1);
  logic [CNT_W-1:0] r_offset;
  logic [CNT_W-1:0] r_off_q;
  logic [CNT_W:0]   w_x_sum;

  // Offset snapshot for the frame starting now; the running offset steps for the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_offset <= 12'd0;
      r_off_q  <= 12'd0;
    end else if (w_origin) begin
      r_off_q  <= r_offset;
      r_offset <= (r_offset == OFF_LAST) ? 12'd0 : r_offset + 12'd1;
    end
  end

  // Horizontal wrap of the scrolled coordinate back into the active width.
  always_comb begin
    w_x_sum = {1'b0, w_x} + {1'b0, r_off_q};
    if (w_x_sum >= (CNT_W+1)'(H_ACTIVE)) begin
      w_x_eff = CNT_W'(w_x_sum - (CNT_W+1)'(H_ACTIVE));
    end else begin
      w_x_eff = w_x_sum[CNT_W-1:0];
    end
  end
`else
  assign w_x_eff = w_x;
`endif

  // Bar index by threshold compare; the last bar takes any remainder pixels.
  always_comb begin
    w_bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (w_x_eff >= CNT_W'(k * BAR_W)) begin
        w_bar_idx = 3'(k);
      end else begin
        w_bar_idx = w_bar_idx;
      end
    end
  end

  assign w_chk_x = |((w_x_eff >> CHK_LOG2) & 12'd1);
  assign w_chk_y = |((w_y >> CHK_LOG2) & 12'd1);

  // Pixel colour for the latched pattern.
  always_comb begin
    w_mask = bar_mask(w_bar_idx);
    case (r_mode_q)
      PAT_BARS:    w_rgb = {{COLOR_W{w_mask[2]}}, {COLOR_W{w_mask[1]}}, {COLOR_W{w_mask[0]}}};
      PAT_RAMP:    w_rgb = {3{w_x_eff[COLOR_W-1:0]}};
      PAT_CHECKER: w_rgb = {(3*COLOR_W){w_chk_x ^ w_chk_y}};
      PAT_SOLID:   w_rgb = r_solid_q;
      default:     w_rgb = {(3*COLOR_W){1'b0}};
    endcase
  end

  // Output register: sync polarity applied here, so reset holds every output low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      r_de  <= 1'b0;
      r_fs  <= 1'b0;
      r_rgb <= {(3*COLOR_W){1'b0}};
    end else begin
      r_hs  <= w_hs_act ? HS_POL : ~HS_POL;
      r_vs  <= w_vs_act ? VS_POL : ~VS_POL;
      r_de  <= w_de;
      r_fs  <= w_fs;
      r_rgb <= w_de ? w_rgb : {(3*COLOR_W){1'b0}};
    end
  end

  assign bus.hs          = r_hs;
  assign bus.vs          = r_vs;
  assign bus.de          = r_de;
  assign bus.frame_start = r_fs;
  assign bus.rgb_r       = r_rgb[3*COLOR_W-1 -: COLOR_W];
  assign bus.rgb_g       = r_rgb[2*COLOR_W-1 -: COLOR_W];
  assign bus.rgb_b       = r_rgb[COLOR_W-1 -: COLOR_W];

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen on a tiny 24x8 raster.
module tb_video_pattern_gen;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 4, VFP = 1, VSW = 2, VBP = 1;
  localparam int HB = HFP + HSW + HBP, VB = VFP + VSW + VBP;
  localparam int HT = HB + HA, VT = VB + VA, FT = HT * VT;
  localparam int CW = 8, CL = 1;
`ifdef PATTERN_SCROLL_EN
  localparam int SCROLL = 1;
`else
  localparam int SCROLL = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  video_pattern_gen_if #(.COLOR_W(CW)) bus ();

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(CW), .CHK_LOG2(CL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int e     = 0;
  int cnt_hs, cnt_vs, cnt_de, cnt_fs;
  logic [25:0] fm [64];
  logic [23:0] cap [4][VA][HA];
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  typedef struct {
    int          frame;
    int          x;
    int          y;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs [16];

  typedef struct {
    logic [1:0]  mode;
    logic [23:0] solid;
  } cfg_t;
  cfg_t sched [4];

  function automatic logic [23:0] pix(input logic [25:0] cfg, input int x, input int y, input int f);
    int xe;
    int bi;
    logic [7:0] r8;
    xe = (x + SCROLL * f) % HA;
    bi = xe / (HA / 8);
    if (bi > 7) bi = 7;
    r8 = 8'(xe);
    case (cfg[25:24])
      2'd0:    return bars[bi];
      2'd1:    return {r8, r8, r8};
      2'd2:    return ((((xe >> CL) ^ (y >> CL)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: return cfg[23:0];
    endcase
  endfunction

  // Expected {hs,vs,de,frame_start,rgb} after edge ee since reset release.
  function automatic logic [27:0] model(input int ee);
    int n, h, v, f;
    logic hs, vs, de, fs;
    logic [23:0] rgb;
    if (ee < 2) return 28'd0;
    n  = ee - 2;
    h  = n % HT;
    v  = (n / HT) % VT;
    f  = n / FT;
    hs = (h >= HFP) && (h < HFP + HSW);
    vs = (v >= VFP) && (v < VFP + VSW);
    de = (h >= HB) && (v >= VB);
    fs = (n % FT) == 0;
    rgb = de ? pix(fm[f], h - HB, v - VB, f) : 24'h000000;
    return {hs, vs, de, fs, rgb};
  endfunction

  task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] outs();
    return {bus.hs, bus.vs, bus.de, bus.frame_start, bus.rgb_r, bus.rgb_g, bus.rgb_b};
  endfunction

  task automatic step();
    logic [27:0] act;
    int n, h, v, f;
    @(posedge clk);
    e++;
    if (((e - 1) % FT) == 0 && ((e - 1) / FT) < 64) fm[(e - 1) / FT] = {bus.mode, bus.solid_rgb};
    #1;
    act = outs();
    total++;
    if (act !== model(e)) begin
      bad++;
      $display("FAIL pixel e=%0d: actual=%h required=%h", e, act, model(e));
    end
    if (e >= 2) begin
      n = e - 2;
      h = n % HT;
      v = (n / HT) % VT;
      f = n / FT;
      if (f < 4 && h >= HB && v >= VB) cap[f][v - VB][h - HB] = act[23:0];
      cnt_hs += int'(bus.hs);
      cnt_vs += int'(bus.vs);
      cnt_de += int'(bus.de);
      cnt_fs += int'(bus.frame_start);
      if ((n % FT) == FT - 1) begin
        chk("hs_per_frame", 28'(cnt_hs), 28'(HSW * VT));
        chk("vs_per_frame", 28'(cnt_vs), 28'(VSW * HT));
        chk("de_per_frame", 28'(cnt_de), 28'(HA * VA));
        chk("fs_per_frame", 28'(cnt_fs), 28'd1);
        cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_fs = 0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int xs, k;
    logic [23:0] got;
    sched[0] = '{2'd0, 24'h000000};
    sched[1] = '{2'd3, 24'h123456};
    sched[2] = '{2'd2, 24'h000000};
    sched[3] = '{2'd1, 24'h000000};
    vecs[0]  = '{0, 0, 0, 24'hFFFFFF};  vecs[1]  = '{0, 3, 1, 24'hFFFF00};
    vecs[2]  = '{0, 4, 2, 24'h00FFFF};  vecs[3]  = '{0, 7, 3, 24'h00FF00};
    vecs[4]  = '{0, 8, 0, 24'hFF00FF};  vecs[5]  = '{0, 11, 1, 24'hFF0000};
    vecs[6]  = '{0, 12, 2, 24'h0000FF}; vecs[7]  = '{0, 15, 3, 24'h000000};
    vecs[8]  = '{1, 0, 0, 24'h123456};  vecs[9]  = '{1, 15, 3, 24'h123456};
    vecs[10] = '{2, 0, 0, 24'h000000};  vecs[11] = '{2, 2, 0, 24'hFFFFFF};
    vecs[12] = '{2, 0, 2, 24'hFFFFFF};  vecs[13] = '{2, 3, 2, 24'h000000};
    vecs[14] = '{3, 5, 1, 24'h050505};  vecs[15] = '{3, 15, 3, 24'h0F0F0F};
    cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_fs = 0;

    bus.mode = sched[0].mode;
    bus.solid_rgb = sched[0].solid;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", outs(), 28'd0);
    rst = 1'b0;
    e = 0;

    // Scheduled frames; each new mode is applied halfway through the previous frame.
    for (int fr = 0; fr < 4; fr++) begin
      run(FT / 2);
      if (fr < 3) begin
        bus.mode = sched[fr + 1].mode;
        bus.solid_rgb = sched[fr + 1].solid;
      end
      run(FT / 2);
    end
    run(4);
    for (int i = 0; i < 16; i++) begin
      xs = ((vecs[i].x - SCROLL * vecs[i].frame) % HA + HA) % HA;
      got = cap[vecs[i].frame][vecs[i].y][xs];
      total++;
      if (got !== vecs[i].exp) begin
        bad++;
        $display("FAIL table[%0d] f=%0d x=%0d y=%0d: actual=%h required=%h",
                 i, vecs[i].frame, vecs[i].x, vecs[i].y, got, vecs[i].exp);
      end
    end

    // Random pattern changes at random points in each frame.
    for (int fr = 0; fr < 20; fr++) begin
      k = int'($urandom_range(1, FT - 2));
      run(k);
      bus.mode = 2'($urandom_range(0, 3));
      bus.solid_rgb = 24'($urandom);
      run(FT - k);
    end

    // Asynchronous reset in the middle of a line.
    run(30);
    #2;
    rst = 1'b1;
    #1;
    chk("async_clear", outs(), 28'd0);
    bus.mode = 2'd2;
    bus.solid_rgb = 24'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("held_in_reset", outs(), 28'd0);
    rst = 1'b0;
    e = 0;
    cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_fs = 0;
    step();
    chk("restart_e1_fs", 28'(bus.frame_start), 28'd0);
    step();
    chk("restart_e2_fs", 28'(bus.frame_start), 28'd1);
    run(2 * FT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

Parametrised video timing and test-pattern source for the HDMI display path. Produces hs/vs/de and COLOR_W-bit RGB for any raster supplied as parameters, not compile-time resolution macros. Pattern is runtime-selectable: colour bars, grey ramp, checkerboard or solid colour. Sits in front of the HDMI encoder and replaces fixed-resolution colour-bar sources for bring-up and board test.

## Interface
- H_ACTIVE, 1280, active pixels per line
- H_FP / H_SYNC / H_BP, 110 / 40 / 220, horizontal porch/sync widths (pixels)
- V_ACTIVE, 720, active lines
- V_FP / V_SYNC / V_BP, 5 / 5 / 20, vertical porch/sync widths (lines)
- HS_POL / VS_POL, 1 / 1, sync active level (1 = positive)
- COLOR_W, 8, bits per colour channel (4..12)
- CHK_LOG2, 5, checker square size is 2^CHK_LOG2 pixels
- clk  in  1  pixel clock
- rst  in  1  reset; one clock domain, asynchronous, active-high
- mode  in  2  pattern: 0 bars, 1 ramp, 2 checker, 3 solid
- solid_rgb  in  3*COLOR_W  {r,g,b} for mode 3
- hs, vs, de  out  1  sync and data-enable
- rgb_r, rgb_g, rgb_b  out  COLOR_W  pixel data, zero when de=0
- frame_start  out  1  one-cycle pulse, aligned with first pixel period of each frame (h=0, v=0)

## Operation
- Counters: h_cnt 0..H_TOTAL-1 wraps; v_cnt increments when h_cnt=H_TOTAL-1 and wraps at V_TOTAL-1. Totals are sums of the four widths. Counters are 12 bits; parameters must give totals ≤ 4096.
- Line order is FP, SYNC, BP, ACTIVE; frame order is the same in lines.
  - hs active for h_cnt in [H_FP, H_FP+H_SYNC).
  - vs active for v_cnt in [V_FP, V_FP+V_SYNC), changing only at line start.
  - de when h_cnt ≥ H_FP+H_SYNC+H_BP and v_cnt ≥ V_FP+V_SYNC+V_BP.
- Coordinates: x = h_cnt − H_BLANK and y = v_cnt − V_BLANK, valid only during de.
- Mode latch: mode and solid_rgb are sampled into mode_q/solid_q at h_cnt=0, v_cnt=0 only. Mid-frame changes never tear a frame.
- Pattern mode 0, bars:
  - BAR_W = H_ACTIVE/8 (integer division).
  - Bar k covers x_eff in [k·BAR_W, (k+1)·BAR_W); bar 7 also absorbs the remainder.
  - Order: white, yellow, cyan, green, magenta, red, blue, black.
  - Full scale is all-ones COLOR_W.
- Pattern mode 1, ramp: r=g=b=x_eff[COLOR_W-1:0], wrapping every 2^COLOR_W pixels.
- Pattern mode 2, checker: white if x_eff[CHK_LOG2]^y[CHK_LOG2] is 1, else black.
- Pattern mode 3, solid: solid_q.
- x_eff = x when PATTERN_SCROLL_EN is absent (see Configuration).

## Timing
- Reset values: all counters 0; mode_q=0; solid_q=0; scroll offset 0. All outputs are low or zero, and hs/vs read 0 during reset regardless of polarity.
- After reset release, hs/vs go to inactive level (~POL) one cycle later.
- Pipeline is 2 stages, counters → decode/coords → registered outputs. hs, vs, de, rgb_* and frame_start are mutually aligned, 2 clocks after the counter state that produces them.
- rgb_* is zero whenever the aligned de=0.
- Reset asserted mid-frame: outputs clear asynchronously and the raster restarts at h=0, v=0. The first frame_start follows 2 cycles after release.
- Output period: exactly H_TOTAL clocks per line and H_TOTAL·V_TOTAL clocks per frame, with no drift.

## Configuration
- PATTERN_SCROLL_EN defined:
  - An offset register advances by 1 at each frame_start and wraps at H_ACTIVE−1 → 0.
  - x_eff = x+offset, minus H_ACTIVE if ≥ H_ACTIVE.
  - Bars, ramp and checker scroll left 1 pixel/frame; solid is unaffected.
- PATTERN_SCROLL_EN undefined: offset logic absent; x_eff = x.

## Structure
- Package video_pkg holds:
  - mode encodings (PAT_BARS, PAT_RAMP, PAT_CHECKER, PAT_SOLID);
  - the 8-entry bar colour constants as 3-bit on/off masks, expanded to COLOR_W;
  - the standard timing parameter sets (480x272 through 1920x1080) as named constants.
- Sub-module video_timing_gen holds counters, hs/vs/de, x/y and frame_start generation. video_pattern_gen holds the mode latch, scroll and pattern stage.

## Test plan
Bench parameters: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); COLOR_W=8; CHK_LOG2=1.
- Raster check, POL=1: hs high 3 of every 24 clocks; vs high for 48 clocks per 192; de high 64 clocks per frame, 16 per line; frame_start period 192.
- Bars, mode 0: per active line rgb = FFFFFF,FFFFFF, FFFF00×2, 00FFFF×2, 00FF00×2, FF00FF×2, FF0000×2, 0000FF×2, 000000×2.
- Mode change mid-frame (0→3, solid_rgb=123456): the current frame stays bars; the next frame has every de pixel = 12/34/56 and blanking rgb = 0.
- Checker, mode 2: line y=0 gives 00,00,FF,FF repeating; line y=2 is inverted.
- Reset pulse mid-line: outputs 0 immediately; after release, first frame_start at cycle 2; raster identical to a cold start.
- PATTERN_SCROLL_EN, mode 1: frame n pixel x = (x+n) mod 16; frame 16 equals frame 0.
